serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 156 +++++++++++++++
 tb/tb_serial_subtractor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and reports the difference, unsigned borrow-out and signed overflow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_nxt;
  logic             r_br;
  logic             w_br_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_a_msb;
  logic             w_a_msb_nxt;
  logic             r_b_msb;
  logic             w_b_msb_nxt;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] w_d_nxt;
  logic             r_bout;
  logic             w_bout_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;

  // Full-subtractor cell on the current LSBs and running borrow
  logic w_diff;
  logic w_borrow;
  assign w_diff   = r_a[0] ^ r_b[0] ^ r_br;
  assign w_borrow = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_res_nxt   = r_res;
    w_br_nxt    = r_br;
    w_cnt_nxt   = r_cnt;
    w_a_msb_nxt = r_a_msb;
    w_b_msb_nxt = r_b_msb;
    w_d_nxt     = r_d;
    w_bout_nxt  = r_bout;
    w_ovf_nxt   = r_ovf;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_br_nxt    = bin;
          w_a_msb_nxt = a[WIDTH-1];
          w_b_msb_nxt = b[WIDTH-1];
          w_res_nxt   = '0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_a_nxt   = {1'b0, r_a[WIDTH-1:1]};
        w_b_nxt   = {1'b0, r_b[WIDTH-1:1]};
        w_res_nxt = {w_diff, r_res[WIDTH-1:1]};
        w_br_nxt  = w_borrow;
        if (r_cnt == LAST_BIT) begin
          // Final bit: w_diff is the result MSB, so overflow is decided here
          w_d_nxt     = {w_diff, r_res[WIDTH-1:1]};
          w_bout_nxt  = w_borrow;
          w_ovf_nxt   = (r_a_msb ^ r_b_msb) & (w_diff ^ r_a_msb);
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_res   <= w_res_nxt;
      r_br    <= w_br_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a_msb <= w_a_msb_nxt;
      r_b_msb <= w_b_msb_nxt;
      r_d     <= w_d_nxt;
      r_bout  <= w_bout_nxt;
      r_ovf   <= w_ovf_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign d    = r_d;
  assign bout = r_bout;
  assign ovf  = r_ovf;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=16): results, done timing,
// busy span, ignored restarts and mid-operation reset.
module tb_serial_subtractor;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;
  logic         busy;
  logic         done;

  int n_vec;
  int n_err;

  logic [W-1:0] last_d;
  logic         last_bout;
  logic         last_ovf;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } vec_t;

  vec_t vecs [12];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Starts one operation from IDLE and checks every cycle through the return to IDLE.
  task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic bin_i,
                        input logic [W-1:0] exp_d, input logic exp_bout, input logic exp_ovf,
                        input int repulse_k, input string tag);
    int pulses;
    int busy_cyc;
    a     = a_i;
    b     = b_i;
    bin   = bin_i;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    bin      = 1'($urandom);
    pulses   = 0;
    busy_cyc = 0;
    chk({tag, " busy_after_start"}, 32'(busy), 32'(1));
    if (busy) busy_cyc++;
    for (int k = 1; k <= W + 1; k++) begin
      if (k == repulse_k) begin
        start = 1'b1;
        a     = 16'h1234;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) pulses++;
      if (busy) busy_cyc++;
      chk($sformatf("%s done@%0d", tag, k), 32'(done), 32'(k == W));
      if (k < W)
        chk($sformatf("%s hold@%0d", tag, k), 32'({d, bout, ovf}),
            32'({last_d, last_bout, last_ovf}));
    end
    chk({tag, " done_pulses"}, 32'(pulses), 32'(1));
    chk({tag, " busy_cycles"}, 32'(busy_cyc), 32'(W + 1));
    chk({tag, " d"}, 32'(d), 32'(exp_d));
    chk({tag, " bout"}, 32'(bout), 32'(exp_bout));
    chk({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
    last_d    = exp_d;
    last_bout = exp_bout;
    last_ovf  = exp_ovf;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    last_d    = '0;
    last_bout = 1'b0;
    last_ovf  = 1'b0;

    vecs[0]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1]  = '{16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[3]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[4]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5]  = '{16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
    vecs[8]  = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0};
    vecs[10] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[11] = '{16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b1, 1'b1};

    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;

    // Reset asserted between edges must clear outputs without a clock; start is ignored
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    a     = 16'h0005;
    b     = 16'h0003;
    #1;
    chk("reset outputs", 32'({d, bout, ovf, busy, done}), 32'(0));
    @(posedge clk); @(posedge clk); #1;
    chk("start_in_reset busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("post_reset idle busy", 32'(busy), 32'(0));
    chk("post_reset idle done", 32'(done), 32'(0));

    // Back-to-back table: each start lands in the IDLE cycle right after DONE
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout, vecs[i].ovf,
             0, $sformatf("v%0d", i));

    // Restart with different operands during RUN is ignored
    run_op(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 3, "repulse");

    // Idle gap, then reset mid-operation at bit 7
    @(posedge clk); #1;
    a     = 16'h00FF;
    b     = 16'h000F;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midop_reset outputs", 32'({d, bout, ovf, busy, done}), 32'(0));
    last_d    = '0;
    last_bout = 1'b0;
    last_ovf  = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("midop_reset held", 32'({d, bout, ovf, busy, done}), 32'(0));
    rst_n = 1'b1;
    chk("after_release done", 32'(done), 32'(0));
    run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
